// File: rtl/clkdiv_prog.sv
// Programmable integer clock divider: period N hclkin cycles, high time ceil(N/2),
// with glitch-free ratio reload at period boundaries and a one-cycle phase slip.
//
//   state | meaning
//   IDLE  | divider stopped, clkout low, a pending ratio is applied immediately
//   RUN   | cnt walks 0..N-1; ratio swaps and stop requests act at cnt == N-1
module clkdiv_prog #(
  parameter int DIV_W     = 8,
  parameter int DIV_RESET = 2
) (
  input  logic             hclkin,
  input  logic             reset,
  input  logic             enable,
  input  logic [DIV_W-1:0] div_val,
  input  logic             div_load,
  input  logic             calib,
  output logic             clkout,
  output logic             clk_en,
  output logic             busy,
  output logic             div_ack,
  output logic             cfg_err
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state, state_nx;
  logic [DIV_W-1:0] cnt, cnt_nx;
  logic [DIV_W-1:0] ratio, ratio_nx;
  logic [DIV_W-1:0] pend, pend_nx;
  logic [DIV_W:0]   half_nx;
  logic             busy_nx, cfg_err_nx, ack_nx, clkout_nx, clk_en_nx;
  logic             calib_q, calib_rise, boundary, hold, swap;

  always_ff @(posedge hclkin) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      ratio   <= DIV_W'(DIV_RESET);
      pend    <= '0;
      calib_q <= 1'b0;
      clkout  <= 1'b0;
      clk_en  <= 1'b0;
      busy    <= 1'b0;
      div_ack <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      ratio   <= ratio_nx;
      pend    <= pend_nx;
      calib_q <= calib;
      clkout  <= clkout_nx;
      clk_en  <= clk_en_nx;
      busy    <= busy_nx;
      div_ack <= ack_nx;
      cfg_err <= cfg_err_nx;
    end
  end

  assign calib_rise = calib & ~calib_q;
  assign boundary   = (state == RUN) && (cnt == ratio - 1'b1);

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    ratio_nx   = ratio;
    pend_nx    = pend;
    busy_nx    = busy;
    cfg_err_nx = cfg_err;
    ack_nx     = 1'b0;
    hold       = 1'b0;
    swap       = 1'b0;

    case (state)
      IDLE: begin
        cnt_nx = '0;
        swap   = busy;
        if (enable) state_nx = RUN;
      end
      RUN: begin
        // A held boundary cycle stays at N-1 and becomes the real boundary next cycle.
        if (calib_rise) begin
          hold = 1'b1;
        end else if (boundary) begin
          cnt_nx = '0;
          swap   = busy;
          if (!enable) state_nx = IDLE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase

    if (swap) begin
      ratio_nx = pend;
      busy_nx  = 1'b0;
      ack_nx   = 1'b1;
    end

    if (div_load && !busy) begin
      if (div_val < DIV_W'(2)) begin
        cfg_err_nx = 1'b1;
      end else begin
        pend_nx    = div_val;
        busy_nx    = 1'b1;
        cfg_err_nx = 1'b0;
      end
    end

    // Outputs are registered from the next-cycle state so they line up with cnt.
    half_nx = ({1'b0, ratio_nx} + 1'b1) >> 1;
    if (hold) begin
      clkout_nx = clkout;
      clk_en_nx = 1'b0;
    end else begin
      clkout_nx = (state_nx == RUN) && ({1'b0, cnt_nx} < half_nx);
      clk_en_nx = (state_nx == RUN) && (cnt_nx == '0);
    end
  end

endmodule

// File: tb/tb_clkdiv_prog.sv
// Directed bench for clkdiv_prog: ratio loads, illegal loads, phase slip,
// stop at period end and reset discarding a pending ratio.
module tb_clkdiv_prog;

  localparam int DIV_W = 8;

  logic             hclkin = 1'b0;
  logic             reset;
  logic             enable;
  logic [DIV_W-1:0] div_val;
  logic             div_load;
  logic             calib;
  logic             clkout, clk_en, busy, div_ack, cfg_err;

  int errors = 0;
  int checks = 0;
  int cyc_no = 0;

  clkdiv_prog #(.DIV_W(DIV_W), .DIV_RESET(2)) dut (
    .hclkin   (hclkin),
    .reset    (reset),
    .enable   (enable),
    .div_val  (div_val),
    .div_load (div_load),
    .calib    (calib),
    .clkout   (clkout),
    .clk_en   (clk_en),
    .busy     (busy),
    .div_ack  (div_ack),
    .cfg_err  (cfg_err)
  );

  always #5 hclkin = ~hclkin;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc_no, obs, exp);
    end
  endtask

  // Advance one hclkin cycle and check the registered outputs of the new cycle.
  task automatic cyc(input logic e_clk, input logic e_en, input logic e_ack, input logic e_busy);
    @(posedge hclkin);
    #1;
    cyc_no++;
    chk("clkout",  clkout,  e_clk);
    chk("clk_en",  clk_en,  e_en);
    chk("div_ack", div_ack, e_ack);
    chk("busy",    busy,    e_busy);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; div_val = '0; div_load = 1'b0; calib = 1'b0;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("reset_cfg_err", cfg_err, 1'b0);

    // N=2 from reset ratio
    reset = 1'b0; enable = 1'b1;
    cyc(1, 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(0, 0, 0, 0);

    // Load 5 captured on a boundary: deferred one whole period
    div_load = 1'b1; div_val = 8'd5;
    cyc(1, 1, 0, 1);
    div_load = 1'b0;
    cyc(0, 0, 0, 1);
    cyc(1, 1, 1, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);

    // Load 3 at cnt=2 of N=5: 5-cycle period completes, then 2 high / 1 low
    div_load = 1'b1; div_val = 8'd3;
    cyc(0, 0, 0, 1);
    div_load = 1'b0;
    cyc(0, 0, 0, 1);
    cyc(1, 1, 1, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);

    // Illegal load of 1: cfg_err sets, ratio stays 3
    div_load = 1'b1; div_val = 8'd1;
    cyc(1, 1, 0, 0);
    chk("cfg_err_set", cfg_err, 1'b1);
    div_load = 1'b0;
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 1, 0, 0);
    chk("cfg_err_sticky", cfg_err, 1'b1);

    // Legal load of 4 clears cfg_err; an illegal load while busy is ignored
    div_load = 1'b1; div_val = 8'd4;
    cyc(1, 0, 0, 1);
    chk("cfg_err_clear", cfg_err, 1'b0);
    div_val = 8'd1;
    cyc(0, 0, 0, 1);
    chk("cfg_err_busy_ignore", cfg_err, 1'b0);
    div_load = 1'b0;
    cyc(1, 1, 1, 0);
    cyc(1, 0, 0, 0);

    // Calib edge at cnt=1 of N=4: 3 high cycles, next clk_en 5 cycles later
    calib = 1'b1;
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 1, 0, 0);
    calib = 1'b0;
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);

    // Calib edge on the boundary: held at cnt=3, still low
    calib = 1'b1;
    cyc(0, 0, 0, 0);
    cyc(1, 1, 0, 0);

    // Load 6, then drop enable at cnt=1: full 3 high / 3 low, then idle
    calib = 1'b0; div_load = 1'b1; div_val = 8'd6;
    cyc(1, 0, 0, 1);
    div_load = 1'b0;
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(1, 1, 1, 0);
    cyc(1, 0, 0, 0);
    enable = 1'b0;
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);

    // Calib edge in IDLE has no effect
    calib = 1'b1;
    cyc(0, 0, 0, 0);
    calib = 1'b0;

    // Pending load in IDLE, reset before it applies: no ack, ratio back to 2
    div_load = 1'b1; div_val = 8'd9;
    cyc(0, 0, 0, 1);
    div_load = 1'b0; reset = 1'b1;
    cyc(0, 0, 0, 0);
    chk("reset_cfg_err2", cfg_err, 1'b0);
    reset = 1'b0; enable = 1'b1;
    cyc(1, 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clkdiv_prog.md
CLKDIV_PROG -- requirements
Module: clkdiv_prog

Interface
REQ-001 SHALL have parameter DIV_W, default 8, meaning width of the divide-ratio field.
REQ-002 SHALL have parameter DIV_RESET, default 2, meaning the ratio in effect after reset (legal range 2..2^DIV_W-1).
REQ-003 SHALL have port hclkin  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port enable  input  1  run request; level-sensitive.
REQ-006 SHALL have port div_val  input  DIV_W  requested divide ratio N.
REQ-007 SHALL have port div_load  input  1  single-cycle request to load div_val.
REQ-008 SHALL have port calib  input  1  phase-slip request; rising edge acts.
REQ-009 SHALL have port clkout  output  1  registered divided clock.
REQ-010 SHALL have port clk_en  output  1  one-cycle strobe on the first cycle of each clkout high phase.
REQ-011 SHALL have port busy  output  1  a loaded ratio is pending.
REQ-012 SHALL have port div_ack  output  1  one-cycle pulse when a new ratio takes effect.
REQ-013 SHALL have port cfg_err  output  1  sticky flag: last load request was illegal.

Function
REQ-014 SHALL implement two states, IDLE and RUN, and a period counter cnt of DIV_W bits counting 0..N-1.
REQ-015 SHALL, in RUN, drive clkout=1 for cnt in 0..ceil(N/2)-1 and clkout=0 otherwise; all outputs are registered.
REQ-016 SHALL define the period boundary as the RUN cycle with cnt==N-1; the next cycle has cnt=0.
REQ-017 SHALL assert clk_en exactly on cycles where state is RUN and cnt==0, and never during a calib hold.
REQ-018 SHALL transition IDLE->RUN on the cycle after enable is sampled high; that first RUN cycle has cnt=0, clkout=1, clk_en=1.
REQ-019 SHALL, when enable is sampled low in RUN, finish the current period and enter IDLE after the boundary; no truncated period is produced.
REQ-020 SHALL, in IDLE, hold clkout=0, clk_en=0 and cnt=0.
REQ-021 SHALL, when div_load=1 and busy=0, treat div_val<2 as illegal: set cfg_err=1, leave the ratio and busy unchanged.
REQ-022 SHALL, for a legal load, capture div_val as pending, set busy=1 and clear cfg_err on the next cycle.
REQ-023 SHALL ignore div_load while busy=1; cfg_err is unchanged in that case.
REQ-024 SHALL apply the pending ratio at the next boundary in RUN, or on the cycle after capture in IDLE; it clears busy and pulses div_ack on the first cycle the new N is in effect.
REQ-025 SHALL, when a legal load is captured on a boundary cycle, defer application to the following boundary.
REQ-026 SHALL detect a rising edge of calib from a registered copy; in RUN it holds cnt and all outputs for one extra cycle, delaying all subsequent edges by one hclkin period.
REQ-027 SHALL hold at cnt==N-1 when calib acts on a boundary cycle; the boundary and any pending ratio swap occur on the extra cycle.
REQ-028 SHALL ignore calib edges in IDLE.
REQ-029 SHALL produce a steady-state period of exactly N hclkin cycles, high time ceil(N/2), for every N in 2..2^DIV_W-1.

Reset
REQ-030 SHALL, while reset=1, force state=IDLE, cnt=0, ratio=DIV_RESET, pending cleared, calib history=0, and clkout=0, clk_en=0, busy=0, div_ack=0, cfg_err=0.
REQ-031 SHALL discard a pending ratio on reset mid-operation with no div_ack; reset has priority over all other inputs.

Verification
REQ-032 SHALL cover: reset, enable=1 with N=2 -> clkout 1,0,1,0... starting the cycle after enable; clk_en on every clkout-high cycle.
REQ-033 SHALL cover: RUN N=5, load div_val=3 mid-period -> busy=1; the current 5-cycle period (3 high, 2 low) completes; div_ack pulses with cnt=0; later periods are 2 high, 1 low.
REQ-034 SHALL cover: div_load with div_val=1 -> cfg_err=1, ratio unchanged; a legal load of 4 clears cfg_err.
REQ-035 SHALL cover: RUN N=4, calib rising edge at cnt=1 -> clkout high for 3 cycles in that period; the next clk_en is 5 cycles after the previous one.
REQ-036 SHALL cover: RUN N=6, enable dropped at cnt=1 -> the period completes (3 high, 3 low), then IDLE with clkout=0; reset asserted with busy=1 -> busy=0, no div_ack, ratio=DIV_RESET.
